// File: rtl/mc_batch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_batch_ctrl_if
// Description : Start/seed/done/result handshake between the batch controller
//               and the single-run simulation manager.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_batch_ctrl_if;
    logic        sim_start;
    logic [22:0] sim_seed;
    logic        sim_done;
    logic        sim_y;

    modport master (
        output sim_start,
        output sim_seed,
        input  sim_done,
        input  sim_y
    );

    modport slave (
        input  sim_start,
        input  sim_seed,
        output sim_done,
        output sim_y
    );
endinterface
`default_nettype wire

// File: rtl/mc_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_batch_ctrl
// Description : Runs a batch of seeded simulations, counts depleted-queue
//               outcomes and divides hits by runs into an 8-bit probability.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_batch_ctrl #(
    parameter int N_W  = 16,
    parameter int TO_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             go,
    input  wire logic [N_W-1:0]   n_runs,
    input  wire logic [22:0]      base_seed,
    mc_batch_ctrl_if.master       sim,
    output logic [N_W-1:0]        hits,
    output logic [N_W-1:0]        runs_done,
    output logic [7:0]            prob,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LAUNCH = 3'd1;
    localparam logic [2:0] c_S_GUARD  = 3'd2;
    localparam logic [2:0] c_S_WAIT   = 3'd3;
    localparam logic [2:0] c_S_DIV    = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;

    logic [2:0]     r_state;
    logic [N_W-1:0] r_n;
    logic [22:0]    r_base;
    logic [22:0]    r_seed;
    logic [N_W-1:0] r_hits;
    logic [N_W-1:0] r_runs;
    logic [7:0]     r_prob;
    logic           r_timeout;
    logic [TO_W-1:0] r_wdog;
    logic [N_W:0]   r_rem;
    logic [6:0]     r_quo;
    logic [2:0]     r_div_cnt;

    logic [N_W-1:0]  w_runs_inc;
    logic [N_W-1:0]  w_hits_inc;
    logic [TO_W-1:0] w_wdog_inc;
    logic [22:0]     w_seed_first;
    logic [22:0]     w_seed_sum;
    logic [22:0]     w_seed_next;
    logic [N_W:0]    w_rem_sh;
    logic [N_W:0]    w_n_ext;
    logic            w_qbit;
    logic [N_W:0]    w_rem_next;

    assign w_runs_inc   = r_runs + 1'b1;
    assign w_hits_inc   = r_hits + N_W'(sim.sim_y);
    assign w_wdog_inc   = r_wdog + 1'b1;

    // An all-zero LFSR seed would lock the generator, so 0 maps to 1.
    assign w_seed_first = (base_seed == 23'd0) ? 23'd1 : base_seed;
    assign w_seed_sum   = r_base + 23'(w_runs_inc);
    assign w_seed_next  = (w_seed_sum == 23'd0) ? 23'd1 : w_seed_sum;

    assign w_rem_sh     = r_rem << 1;
    assign w_n_ext      = {1'b0, r_n};
    assign w_qbit       = (w_rem_sh >= w_n_ext);
    assign w_rem_next   = w_qbit ? (w_rem_sh - w_n_ext) : w_rem_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_n       <= '0;
            r_base    <= '0;
            r_seed    <= '0;
            r_hits    <= '0;
            r_runs    <= '0;
            r_prob    <= '0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div_cnt <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (go) begin
                        r_n       <= n_runs;
                        r_base    <= base_seed;
                        r_hits    <= '0;
                        r_runs    <= '0;
                        r_prob    <= '0;
                        r_timeout <= 1'b0;
                        if (n_runs == '0) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_seed  <= w_seed_first;
                            r_state <= c_S_LAUNCH;
                        end
                    end
                end
                c_S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= c_S_GUARD;
                end
                // sim_done may still hold the previous run's result here.
                c_S_GUARD: begin
                    r_state <= c_S_WAIT;
                end
                c_S_WAIT: begin
                    if (sim.sim_done) begin
                        r_hits <= w_hits_inc;
                        r_runs <= w_runs_inc;
                        if (w_runs_inc == r_n) begin
                            r_rem     <= {1'b0, w_hits_inc};
                            r_quo     <= '0;
                            r_div_cnt <= '0;
                            r_state   <= c_S_DIV;
                        end else begin
                            r_seed  <= w_seed_next;
                            r_state <= c_S_LAUNCH;
                        end
                    end else if (w_wdog_inc == {TO_W{1'b1}}) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_S_DONE;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                c_S_DIV: begin
                    r_rem     <= w_rem_next;
                    r_quo     <= {r_quo[5:0], w_qbit};
                    r_div_cnt <= r_div_cnt + 1'b1;
                    if (r_div_cnt == 3'd7) begin
                        // hits == n_runs would need a ninth bit; saturate instead.
                        r_prob  <= (r_hits == r_n) ? 8'hFF : {r_quo, w_qbit};
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign sim.sim_start = (r_state == c_S_LAUNCH);
    assign sim.sim_seed  = r_seed;
    assign hits          = r_hits;
    assign runs_done     = r_runs;
    assign prob          = r_prob;
    assign busy          = (r_state != c_S_IDLE);
    assign done          = (r_state == c_S_DONE);
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mc_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_batch_ctrl
// Description : Directed vector bench for mc_batch_ctrl with a sticky-done
//               simulation-manager model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_batch_ctrl;

    localparam int c_LAT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [15:0] n_runs = '0;
    logic [22:0] base_seed = '0;
    logic [15:0] hits;
    logic [15:0] runs_done;
    logic [7:0]  prob;
    logic        busy;
    logic        done;
    logic        timeout;

    mc_batch_ctrl_if sif ();

    mc_batch_ctrl #(.N_W(16), .TO_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .n_runs    (n_runs),
        .base_seed (base_seed),
        .sim       (sif.master),
        .hits      (hits),
        .runs_done (runs_done),
        .prob      (prob),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Simulation-manager model: done stays high until one cycle after start.
    logic [15:0] ypat = '0;
    int          hang_idx = -1;
    int          cyc = 0;
    int          m_cnt = 0;
    int          m_idx = 0;
    int          m_cur = 0;
    int          starts = 0;
    int          done_cnt = 0;
    int          t_start = 0;
    int          t_done = 0;
    int          t_go = 0;
    logic [22:0] seeds [16];

    initial begin
        sif.sim_done = 1'b0;
        sif.sim_y    = 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_cnt        <= 0;
            sif.sim_done <= 1'b0;
            sif.sim_y    <= 1'b0;
        end else begin
            if (go && !busy) begin
                m_idx    <= 0;
                starts   <= 0;
                done_cnt <= 0;
                t_go     <= cyc;
            end
            if (sif.sim_start) begin
                m_cnt   <= c_LAT;
                m_cur   <= m_idx;
                m_idx   <= m_idx + 1;
                if (starts < 16) seeds[starts] <= sif.sim_seed;
                starts  <= starts + 1;
                t_start <= cyc;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == c_LAT) sif.sim_done <= 1'b0;
                if (m_cnt == 1 && m_cur != hang_idx) begin
                    sif.sim_done <= 1'b1;
                    sif.sim_y    <= ypat[m_cur];
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                t_done   <= cyc;
            end
        end
    end

    typedef struct {
        logic [15:0] n;
        logic [22:0] base;
        logic [15:0] y;
        int          hang;
        logic [15:0] e_hits;
        logic [15:0] e_runs;
        logic [7:0]  e_prob;
        logic        e_to;
        int          e_starts;
        logic [22:0] e_s0;
        logic [22:0] e_s1;
        logic [22:0] e_slast;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        chk("done_seen", done_cnt != 0, 1);
    endtask

    task automatic start_batch(input logic [15:0] n, input logic [22:0] b,
                               input logic [15:0] y, input int hang);
        @(negedge clk);
        ypat      = y;
        hang_idx  = hang;
        n_runs    = n;
        base_seed = b;
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        start_batch(v.n, v.base, v.y, v.hang);
        wait_done();
        repeat (3) @(negedge clk);
        chk("hits", hits, v.e_hits);
        chk("runs_done", runs_done, v.e_runs);
        chk("prob", prob, v.e_prob);
        chk("timeout", timeout, v.e_to);
        chk("busy_after", busy, 0);
        chk("done_pulses", done_cnt, 1);
        chk("starts", starts, v.e_starts);
        if (v.e_starts > 0) chk("seed0", seeds[0], v.e_s0);
        if (v.e_starts > 1) chk("seed1", seeds[1], v.e_s1);
        if (v.e_starts > 0) chk("seed_last", seeds[v.e_starts-1], v.e_slast);
    endtask

    initial begin
        //        n   base      y      hang hits runs prob  to st s0        s1        slast
        vecs[0] = '{16'd4, 23'h00000C, 16'h000D, -1, 16'd3, 16'd4, 8'd192, 1'b0, 4, 23'h00000C, 23'h00000D, 23'h00000F};
        vecs[1] = '{16'd3, 23'h000100, 16'h0007, -1, 16'd3, 16'd3, 8'hFF,  1'b0, 3, 23'h000100, 23'h000101, 23'h000102};
        vecs[2] = '{16'd3, 23'h000200, 16'h0000, -1, 16'd0, 16'd3, 8'd0,   1'b0, 3, 23'h000200, 23'h000201, 23'h000202};
        vecs[3] = '{16'd3, 23'h000300, 16'h0002, -1, 16'd1, 16'd3, 8'd85,  1'b0, 3, 23'h000300, 23'h000301, 23'h000302};
        vecs[4] = '{16'd2, 23'h7FFFFF, 16'h0001, -1, 16'd1, 16'd2, 8'd128, 1'b0, 2, 23'h7FFFFF, 23'h000001, 23'h000001};
        vecs[5] = '{16'd5, 23'h000040, 16'h001F,  1, 16'd1, 16'd1, 8'd0,   1'b1, 2, 23'h000040, 23'h000041, 23'h000041};
        vecs[6] = '{16'd0, 23'h000055, 16'h0000, -1, 16'd0, 16'd0, 8'd0,   1'b0, 0, 23'h000000, 23'h000000, 23'h000000};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", sif.sim_start, 0);
        chk("rst_seed", sif.sim_seed, 0);
        chk("rst_hits", hits, 0);
        chk("rst_prob", prob, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            // Watchdog: LAUNCH edge to done sample spans GUARD, 63 WAIT, DONE.
            if (i == 5) chk("wdog_latency", t_done - t_start, 65);
            // Empty batch: IDLE goes straight to DONE.
            if (i == 6) chk("n0_latency", t_done - t_go, 1);
        end

        // go pulsed mid-batch must not restart or resize the batch.
        start_batch(16'd3, 23'h000020, 16'h0005, -1);
        repeat (5) @(negedge clk);
        n_runs = 16'd1;
        go     = 1'b1;
        @(negedge clk);
        go     = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        chk("busy_go_runs", runs_done, 3);
        chk("busy_go_hits", hits, 2);
        chk("busy_go_prob", prob, 170);
        chk("busy_go_starts", starts, 3);
        chk("busy_go_done", done_cnt, 1);

        // Reset while waiting on the second run.
        start_batch(16'd4, 23'h000005, 16'h000F, -1);
        for (int k = 0; k < 200; k++) begin
            if (starts >= 2) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("pre_rst_hits", hits, 1);
        chk("pre_rst_runs", runs_done, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", sif.sim_start, 0);
        chk("mid_rst_hits", hits, 0);
        chk("mid_rst_runs", runs_done, 0);
        chk("mid_rst_seed", sif.sim_seed, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_batch_ctrl.md
# mc_batch_ctrl

Batch controller and estimator sitting directly downstream of the single-run simulation manager. It launches a programmed number of back-to-back Hawkes order-book simulations, giving each run a distinct LFSR seed. It counts runs that end with the ask queue depleted (`y=1`) and, at batch end, computes the 8-bit fixed-point depletion probability using a sequential restoring divider. A watchdog aborts the batch if a run never completes.

## Interface
Parameters:
- `N_W`, 16: width of the run and hit counters and of `n_runs`.
- `TO_W`, 16: watchdog width. A run is aborted after 2^TO_W − 1 cycles in WAIT.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start-batch request, sampled in IDLE only.
- `n_runs`  in  N_W  number of simulations; latched on accepted `go`.
- `base_seed`  in  23  seed of run 0; latched on accepted `go`.
- `sim_done`  in  1  `done` of the simulation manager; level, sticky until its next start.
- `sim_y`  in  1  `y` of the simulation manager; valid while `sim_done=1`.
- `sim_start`  out  1  start to the simulation manager; one-cycle pulse.
- `sim_seed`  out  23  seed for the current run.
- `hits`  out  N_W  runs that ended with `y=1`.
- `runs_done`  out  N_W  completed runs.
- `prob`  out  8  floor(hits·256/n_runs), saturated to 8'hFF; unsigned fraction.
- `busy`  out  1  high from the cycle after an accepted `go` through DONE.
- `done`  out  1  one-cycle pulse at batch end.
- `timeout`  out  1  watchdog abort flag; held until the next accepted `go`.

## Operation
- Reset value of all outputs and state is 0. The FSM resets to IDLE.
- **IDLE:** On `go=1`:
  - Latch `n_runs` and `base_seed`.
  - Clear `hits`, `runs_done`, `prob` and `timeout`.
  - If `n_runs=0`, go to DONE. Otherwise go to LAUNCH.
  - `go` in any other state is ignored.
- **LAUNCH:** `sim_start=1`. Clear the watchdog. Go to GUARD.
  - `sim_seed = base_seed + runs_done` (mod 2^23). A result of 0 is replaced by 23'h000001, because an LFSR must not be seeded with 0.
  - `sim_seed` is registered and held stable from LAUNCH until the next LAUNCH.
- **GUARD:** `sim_start=0`. `sim_done` is ignored, because it may still carry the previous run's sticky value. Go to WAIT.
- **WAIT:** The watchdog increments every cycle.
  - On `sim_done=1`: `hits += sim_y` and `runs_done += 1`. If the new `runs_done` equals `n_runs`, go to DIV. Otherwise go to LAUNCH.
  - If the watchdog reaches all-ones before `sim_done`: set `timeout=1`, leave the counters unchanged and go to DONE. `prob` stays 0.
- **DIV:** Restoring division over 8 iterations, one quotient bit per cycle, MSB first.
  - Remainder width is N_W+1. Initialise r = `hits`.
  - Each iteration: r = r<<1. If r ≥ n, then r −= n and q[i]=1.
  - If `hits == n_runs`, force `prob = 8'hFF` instead of the division result.
  - `prob` is written once, at DIV exit. Go to DONE.
- **DONE:** `done=1` for one cycle, then go to IDLE.
  - `hits`, `runs_done`, `prob` and `timeout` hold until the next accepted `go`.
- **Counters:** `hits` ≤ `runs_done` ≤ `n_runs`, so neither counter can overflow.
- **Reset mid-batch:** Drop `sim_start` on the next edge. Return to IDLE with all outputs 0. The simulation manager is not otherwise notified.

## Timing
- Per run: 2 cycles of overhead (LAUNCH, GUARD) plus the simulation latency, measured from the first WAIT cycle to `sim_done` sampled high.
- `sim_done` is sampled only in WAIT. A sticky `done` held through LAUNCH and GUARD is never counted.
- From the final `sim_done` sample to the `done` pulse: 1 cycle (enter DIV), then 8 DIV cycles, then 1 cycle in DONE. Total 10 cycles.
- `n_runs=0`: `done` pulses 2 cycles after `go` is sampled (IDLE→DONE, then DONE).
- `busy` is deasserted in the cycle after `done`. A new `go` is accepted in that same cycle.

## Test plan
- **Basic batch.** `n_runs=4`, `base_seed=23'h0C`. The model asserts `sim_done` 10 cycles after each start, with `y = 1,0,1,1`.
  - Required: `sim_seed` = 0C, 0D, 0E, 0F; `hits=3`; `runs_done=4`; `prob=8'd192`; exactly one `done` pulse; `timeout=0`.
- **Sticky done.** The model keeps `sim_done=1` from the previous run and clears it only one cycle after `sim_start`, exactly like the simulation manager.
  - Required: no double counting; `runs_done` increments once per run.
- **Extremes.**
  - `n_runs=3`, all `y=1` → `prob=8'hFF`.
  - All `y=0` → `prob=0`.
  - `n_runs=3`, `hits=1` → `prob=8'd85`.
- **Watchdog.** `TO_W=6`, `n_runs=5`; the model never completes run 2.
  - Required: `timeout=1` and `done` after 63 WAIT cycles; `runs_done=1`; `prob=0`.
- **Seed wrap.** `base_seed=23'h7FFFFF`, `n_runs=2`.
  - Required: `sim_seed` = 7FFFFF, then 000001 (the 0 is substituted).
- **Control corners.**
  - `n_runs=0` → `done` 2 cycles after `go`, `hits=0`.
  - `go` pulsed while `busy` → ignored.
  - `rst` asserted during WAIT → all outputs 0 on the next edge; a fresh `go` runs correctly.
